// File: rtl/prog_clk_divider.sv
// prog_clk_divider
//   Programmable divider / tick generator. A WIDTH-bit counter runs 0..div_q and
//   fires an event every div_q+1 enabled cycles. Each event produces a registered
//   one-cycle pulse on tick and toggles the square wave on out. Supports runtime
//   divisor load, count enable and a one-shot mode armed by start.
//
// Ports
//   clk     in   1      system clock, all logic on posedge
//   reset   in   1      synchronous, active-high, highest priority
//   en      in   1      count enable; 0 freezes count and out, tick=0
//   load    in   1      capture div_in into the divisor register, clear count
//   div_in  in   WIDTH  new terminal count
//   mode    in   1      0 = continuous, 1 = one-shot
//   start   in   1      one-shot arm/restart pulse, ignored when mode=0
//   out     out  1      square wave, toggles on every event
//   tick    out  1      one-cycle pulse per event
//   busy    out  1      one-shot armed and counting
//   count   out  WIDTH  current counter value
module prog_clk_divider #(
    parameter int unsigned          WIDTH       = 32,
    parameter logic [WIDTH-1:0]     DEFAULT_DIV = WIDTH'(50000000)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] div_in,
    input  logic             mode,
    input  logic             start,
    output logic             out,
    output logic             tick,
    output logic             busy,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] div_q;

    logic [WIDTH-1:0] div_n;
    logic [WIDTH-1:0] count_n;
    logic             out_n;
    logic             tick_n;
    logic             busy_n;
    logic             run;

    // In one-shot mode the counter only advances while armed; with busy=0 it
    // simply freezes, so a mode switch never loses the current count.
    assign run = en && (!mode || busy);

    always_comb begin
        div_n   = div_q;
        count_n = count;
        out_n   = out;
        tick_n  = 1'b0;
        busy_n  = busy;

        if (load) begin
            // Clearing count here keeps count <= div_q even when shrinking the
            // divisor, and swallows any event that was due on this edge.
            div_n   = div_in;
            count_n = '0;
        end else if (start && mode) begin
            busy_n  = 1'b1;
            count_n = '0;
        end else if (run) begin
            if (count == div_q) begin
                count_n = '0;
                tick_n  = 1'b1;
                out_n   = ~out;
                if (mode) begin
                    busy_n = 1'b0;
                end
            end else begin
                count_n = count + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q <= DEFAULT_DIV;
            count <= '0;
            out   <= 1'b0;
            tick  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            div_q <= div_n;
            count <= count_n;
            out   <= out_n;
            tick  <= tick_n;
            busy  <= busy_n;
        end
    end

endmodule

// File: tb/tb_prog_clk_divider.sv
module tb_prog_clk_divider;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic         load;
    logic [W-1:0] div_in;
    logic         mode;
    logic         start;
    logic         out;
    logic         tick;
    logic         busy;
    logic [W-1:0] count;

    int n_pass  = 0;
    int n_total = 0;

    prog_clk_divider #(
        .WIDTH       (W),
        .DEFAULT_DIV (8'd3)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .load   (load),
        .div_in (div_in),
        .mode   (mode),
        .start  (start),
        .out    (out),
        .tick   (tick),
        .busy   (busy),
        .count  (count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b1; load = 1'b0; div_in = '0; mode = 1'b0; start = 1'b0;
        step();
        step();
        n_total++;
        if ({count, out, tick, busy} !== {8'd0, 1'b0, 1'b0, 1'b0})
            $display("FAIL reset: count=%0d out=%b tick=%b busy=%b, expected count=0 out=0 tick=0 busy=0",
                     count, out, tick, busy);
        else n_pass++;
        reset = 1'b0;
    endtask

    // Default divisor 3: tick after edges 4,8,12,16; out 1,0,1,0.
    task automatic test_free_run();
        for (int k = 1; k <= 16; k++) begin
            logic [W-1:0] ec;
            logic         et, eo;
            step();
            ec = W'(k % 4);
            et = (k % 4) == 0;
            eo = ((k / 4) % 2) == 1;
            n_total++;
            if ({count, out, tick, busy} !== {ec, eo, et, 1'b0})
                $display("FAIL free_run[%0d]: count=%0d out=%b tick=%b busy=%b, expected count=%0d out=%b tick=%b busy=0",
                         k, count, out, tick, busy, ec, eo, et);
            else n_pass++;
        end
    endtask

    task automatic test_load_mid_run();
        step();
        step();
        load = 1'b1; div_in = 8'd1;
        step();
        load = 1'b0;
        n_total++;
        if ({count, out, tick} !== {8'd0, 1'b0, 1'b0})
            $display("FAIL load_mid_run: count=%0d out=%b tick=%b, expected count=0 out=0 tick=0",
                     count, out, tick);
        else n_pass++;
        for (int i = 1; i <= 6; i++) begin
            logic [W-1:0] ec;
            logic         et, eo;
            step();
            ec = W'(i % 2);
            et = (i % 2) == 0;
            eo = ((i / 2) % 2) == 1;
            n_total++;
            if ({count, out, tick} !== {ec, eo, et})
                $display("FAIL div2_run[%0d]: count=%0d out=%b tick=%b, expected count=%0d out=%b tick=%b",
                         i, count, out, tick, ec, eo, et);
            else n_pass++;
        end
    endtask

    // State on entry: div_q=1, count=0, out=1.
    task automatic test_load_at_terminal();
        step();
        n_total++;
        if ({count, tick} !== {8'd1, 1'b0})
            $display("FAIL pre_terminal: count=%0d tick=%b, expected count=1 tick=0", count, tick);
        else n_pass++;
        load = 1'b1; div_in = 8'd0;
        step();
        load = 1'b0;
        n_total++;
        if ({count, out, tick} !== {8'd0, 1'b1, 1'b0})
            $display("FAIL load_at_terminal: count=%0d out=%b tick=%b, expected count=0 out=1 tick=0",
                     count, out, tick);
        else n_pass++;
        for (int j = 1; j <= 4; j++) begin
            logic eo;
            step();
            eo = (j % 2) == 0;
            n_total++;
            if ({count, out, tick} !== {8'd0, eo, 1'b1})
                $display("FAIL div0_run[%0d]: count=%0d out=%b tick=%b, expected count=0 out=%b tick=1",
                         j, count, out, tick, eo);
            else n_pass++;
        end
    endtask

    // State on entry: div_q=0, out=1.
    task automatic test_enable_hold();
        load = 1'b1; div_in = 8'd3;
        step();
        load = 1'b0;
        step();
        step();
        n_total++;
        if ({count, out, tick} !== {8'd2, 1'b1, 1'b0})
            $display("FAIL pre_hold: count=%0d out=%b tick=%b, expected count=2 out=1 tick=0",
                     count, out, tick);
        else n_pass++;
        en = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            step();
            n_total++;
            if ({count, out, tick} !== {8'd2, 1'b1, 1'b0})
                $display("FAIL en_hold[%0d]: count=%0d out=%b tick=%b, expected count=2 out=1 tick=0",
                         i, count, out, tick);
            else n_pass++;
        end
        en = 1'b1;
        step();
        n_total++;
        if ({count, tick} !== {8'd3, 1'b0})
            $display("FAIL resume1: count=%0d tick=%b, expected count=3 tick=0", count, tick);
        else n_pass++;
        step();
        n_total++;
        if ({count, out, tick} !== {8'd0, 1'b0, 1'b1})
            $display("FAIL resume2: count=%0d out=%b tick=%b, expected count=0 out=0 tick=1",
                     count, out, tick);
        else n_pass++;
    endtask

    // State on entry: div_q=3, count=0, out=0.
    task automatic test_one_shot();
        mode = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        n_total++;
        if ({count, tick, busy} !== {8'd0, 1'b0, 1'b1})
            $display("FAIL arm: count=%0d tick=%b busy=%b, expected count=0 tick=0 busy=1", count, tick, busy);
        else n_pass++;
        for (int k = 1; k <= 7; k++) begin
            logic [W-1:0] ec;
            logic         et, eb, eo;
            step();
            ec = (k < 4) ? W'(k) : 8'd0;
            et = (k == 4);
            eb = (k < 4);
            eo = (k >= 4);
            n_total++;
            if ({count, out, tick, busy} !== {ec, eo, et, eb})
                $display("FAIL one_shot[%0d]: count=%0d out=%b tick=%b busy=%b, expected count=%0d out=%b tick=%b busy=%b",
                         k, count, out, tick, busy, ec, eo, et, eb);
            else n_pass++;
        end
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        n_total++;
        if ({count, busy} !== {8'd2, 1'b1})
            $display("FAIL rearm_count: count=%0d busy=%b, expected count=2 busy=1", count, busy);
        else n_pass++;
        start = 1'b1;
        step();
        start = 1'b0;
        n_total++;
        if ({count, tick, busy} !== {8'd0, 1'b0, 1'b1})
            $display("FAIL restart: count=%0d tick=%b busy=%b, expected count=0 tick=0 busy=1", count, tick, busy);
        else n_pass++;
        for (int k = 1; k <= 4; k++) begin
            logic et, eb;
            step();
            et = (k == 4);
            eb = (k < 4);
            n_total++;
            if ({tick, busy} !== {et, eb})
                $display("FAIL restart_run[%0d]: tick=%b busy=%b, expected tick=%b busy=%b", k, tick, busy, et, eb);
            else n_pass++;
        end
        n_total++;
        if ({count, out} !== {8'd0, 1'b0})
            $display("FAIL restart_end: count=%0d out=%b, expected count=0 out=0", count, out);
        else n_pass++;
    endtask

    // Reset wins over load/start; the restored divisor must be 3 again.
    task automatic test_reset_mid_run();
        mode = 1'b0;
        for (int k = 1; k <= 6; k++) step();
        n_total++;
        if ({count, out} !== {8'd2, 1'b1})
            $display("FAIL pre_reset: count=%0d out=%b, expected count=2 out=1", count, out);
        else n_pass++;
        reset = 1'b1; load = 1'b1; div_in = 8'd7; start = 1'b1; mode = 1'b1;
        step();
        reset = 1'b0; load = 1'b0; start = 1'b0; mode = 1'b0;
        n_total++;
        if ({count, out, tick, busy} !== {8'd0, 1'b0, 1'b0, 1'b0})
            $display("FAIL reset_mid_run: count=%0d out=%b tick=%b busy=%b, expected count=0 out=0 tick=0 busy=0",
                     count, out, tick, busy);
        else n_pass++;
        for (int k = 1; k <= 4; k++) begin
            logic [W-1:0] ec;
            logic         et;
            step();
            ec = W'(k % 4);
            et = (k == 4);
            n_total++;
            if ({count, tick, out} !== {ec, et, et})
                $display("FAIL post_reset[%0d]: count=%0d tick=%b out=%b, expected count=%0d tick=%b out=%b",
                         k, count, tick, out, ec, et, et);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_load_mid_run();
        test_load_at_terminal();
        test_enable_hold();
        test_one_shot();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
